// File: rtl/coef_div_c3.sv
// coef_div_c3: restoring divider by a constant COEF, one quotient bit per cycle, saturating q.
// Define COEF_DIV_ROUND_EN to round q to nearest at the cost of one extra cycle before DONE.
module coef_div_c3 #(
  parameter int unsigned COEF = 8,
  parameter int unsigned DW   = 16,
  parameter int unsigned QW   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [QW-1:0] q,
  output logic [7:0]    rem,
  output logic          ovf,
  output logic          out_valid,
  input  logic          out_ready
);
  localparam int unsigned CW = $clog2(DW);
  typedef enum logic [1:0] {IDLE, DIV, DONE, RND} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] dq_q, quo_d;
  logic [7:0] rem_q, rem_d;
  logic [8:0] rem_sh;
  logic ge, ld;
  logic [CW-1:0] cnt_q;
  logic [QW-1:0] q_q, q_d;
  logic ovf_q, ovf_d;
  // dq_q shifts dividend bits out of the top while quotient bits enter at the bottom
  always_comb begin
    rem_sh = {rem_q, dq_q[DW-1]};
    ge     = rem_sh >= 9'(COEF);
    rem_d  = ge ? 8'(rem_sh - 9'(COEF)) : rem_sh[7:0];
    quo_d  = {dq_q[DW-2:0], ge};
  end
`ifdef COEF_DIV_ROUND_EN
  localparam state_t POST = RND;
  logic [DW:0] sum;
  always_comb begin
    sum   = {1'b0, dq_q} + (DW+1)'({rem_q, 1'b0} >= 9'(COEF));
    ovf_d = (sum >> QW) != '0;
    q_d   = ovf_d ? '1 : QW'(sum);
    ld    = state_q == RND;
  end
`else
  localparam state_t POST = DONE;
  always_comb begin
    ovf_d = (quo_d >> QW) != '0;
    q_d   = ovf_d ? '1 : QW'(quo_d);
    ld    = state_q == DIV && cnt_q == '0;
  end
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = in_valid ? DIV : IDLE;
      DIV:     state_d = cnt_q == '0 ? POST : DIV;
      RND:     state_d = DONE;
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
    q         = q_q;
    rem       = rem_q;
    ovf       = ovf_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dq_q  <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        dq_q  <= in_data;
        rem_q <= '0;
        cnt_q <= CW'(DW-1);
      end else if (state_q == DIV) begin
        dq_q  <= quo_d;
        rem_q <= rem_d;
        cnt_q <= cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
      end
      if (ld) begin
        q_q   <= q_d;
        ovf_q <= ovf_d;
      end
    end
endmodule

// File: tb/tb_coef_div_c3.sv
// tb_coef_div_c3: table-driven scoreboard bench for coef_div_c3 (COEF=8, DW=16, QW=8).
module tb_coef_div_c3;
  localparam int DW = 16;
  localparam int COEF = 8;
`ifdef COEF_DIV_ROUND_EN
  localparam int LAT = DW + 1;
`else
  localparam int LAT = DW;
`endif
  logic clk = 0, rst_n = 1, in_valid = 0, out_ready = 1;
  logic [15:0] in_data = '0;
  logic [7:0] q, rem;
  logic ovf, in_ready, out_valid;
  coef_div_c3 #(.COEF(8), .DW(16), .QW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .q(q), .rem(rem), .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int pass_n = 0, tot_n = 0;
  typedef struct {logic [7:0] q; logic [7:0] r; logic o; int acc;} exp_t;
  typedef struct {logic [15:0] d; logic [7:0] q; logic [7:0] r; logic o;} vec_t;
  exp_t sb[$];
  exp_t me;
  vec_t tbl[11];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
  endtask
  task automatic fail(input string nm);
    tot_n++;
    $display("FAIL %s: got timeout/unexpected event want none (cyc %0d)", nm, cyc);
  endtask
  // truncated expectations come from the table; rounding is re-derived from the dividend
  function automatic exp_t model(input vec_t v, input int acc);
    exp_t e;
`ifdef COEF_DIV_ROUND_EN
    int full;
`endif
    e.q = v.q; e.r = v.r; e.o = v.o; e.acc = acc;
`ifdef COEF_DIV_ROUND_EN
    full = int'(v.d) / COEF + ((2 * (int'(v.d) % COEF) >= COEF) ? 1 : 0);
    e.o = full > 255;
    e.q = e.o ? 8'hff : 8'(full);
`endif
    return e;
  endfunction
  task automatic send(input vec_t v);
    int n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin fail("send_timeout"); return; end
    in_valid = 1; in_data = v.d;
    sb.push_back(model(v, cyc + 1));
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 300) begin @(negedge clk); n++; end
    if (sb.size() != 0 || !in_ready) fail("drain_timeout");
  endtask
  logic ov_prev = 0;
  int ov_start = 0;
  always @(negedge clk) begin
    #2;
    if (out_valid && !ov_prev) ov_start = cyc;
    ov_prev = out_valid;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) fail("unexpected_out_valid");
      else begin
        me = sb.pop_front();
        chk("q", q, me.q);
        chk("rem", rem, me.r);
        chk("ovf", ovf, me.o);
        chk("latency", ov_start - me.acc, LAT);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end
  initial begin
    vec_t v;
    int n;
    tbl = '{
      '{16'd2040, 8'd255, 8'd0, 1'b0}, '{16'd1037, 8'd129, 8'd5, 1'b0},
      '{16'd65535, 8'd255, 8'd7, 1'b1}, '{16'd0, 8'd0, 8'd0, 1'b0},
      '{16'd2047, 8'd255, 8'd7, 1'b0}, '{16'd8, 8'd1, 8'd0, 1'b0},
      '{16'd7, 8'd0, 8'd7, 1'b0}, '{16'd2048, 8'd255, 8'd0, 1'b1},
      '{16'd2043, 8'd255, 8'd3, 1'b0}, '{16'd12345, 8'd255, 8'd1, 1'b1},
      '{16'd100, 8'd12, 8'd4, 1'b0}};
    #1 rst_n = 0;
    #10;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", q, 0);
    chk("rst_rem", rem, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 11; i++) send(tbl[i]);
    drain();
    // result held under backpressure while a second request is ignored
    out_ready = 0;
    v = tbl[1];
    send(v);
    in_valid = 1; in_data = 16'h1234;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    if (!out_valid) fail("stall_wait");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_q", q, model(v, 0).q);
      chk("stall_rem", rem, model(v, 0).r);
      chk("stall_ovf", ovf, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("after_ack_in_ready", in_ready, 1);
    chk("after_ack_out_valid", out_valid, 0);
    drain();
    // reset in the middle of a division
    in_valid = 1; in_data = 16'd1000;
    @(negedge clk) in_valid = 0;
    repeat (7) @(negedge clk);
    #1 rst_n = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_q", q, 0);
    chk("midrst_rem", rem, 0);
    chk("midrst_ovf", ovf, 0);
    @(negedge clk) rst_n = 1;
    send(tbl[5]);
    drain();
    send(tbl[3]);
    send(tbl[4]);
    drain();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule

// File: doc/coef_div_c3.md
COEF_DIV_C3 -- requirements
Module: coef_div_c3

Interface
REQ-001 SHALL provide parameter COEF, default 8, meaning the constant divisor, legal range 1..255.
REQ-002 SHALL provide parameter DW, default 16, meaning the dividend (product) width.
REQ-003 SHALL provide parameter QW, default 8, meaning the quotient (recovered sample) width.
REQ-004 SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL provide port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL provide port in_data, input, DW bits: the product to divide.
REQ-007 SHALL provide port in_valid, input, 1 bit: in_data is valid.
REQ-008 SHALL provide port in_ready, output, 1 bit: the block accepts in_data.
REQ-009 SHALL provide port q, output, QW bits: the quotient.
REQ-010 SHALL provide port rem, output, 8 bits: the remainder.
REQ-011 SHALL provide port ovf, output, 1 bit: the true quotient exceeded 2^QW-1 and q is saturated.
REQ-012 SHALL provide port out_valid, output, 1 bit: q, rem and ovf are valid.
REQ-013 SHALL provide port out_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-014 SHALL implement the FSM states IDLE, DIV and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE.
REQ-016 SHALL, on in_valid&in_ready in cycle T, latch in_data, clear the partial remainder, load the iteration counter with DW-1 and enter DIV.
REQ-017 SHALL, in DIV, perform one restoring-division step per cycle, MSB first: shift the remainder left, take in the next dividend bit, subtract COEF when the remainder >= COEF, and shift the resulting quotient bit in.
REQ-018 SHALL leave DIV for DONE after exactly DW steps, then assert out_valid from cycle T+DW+1.
REQ-019 SHALL keep the internal quotient DW bits wide, and set ovf=1 with q=2^QW-1 when any bit above QW-1 is set; otherwise ovf=0 and q holds the low QW bits.
REQ-020 SHALL keep rem < COEF at all times and report it unrounded.
REQ-021 SHALL hold q, rem, ovf and out_valid stable in DONE until out_ready=1.
REQ-022 SHALL, on out_valid&out_ready, return to IDLE on the next edge, with in_ready=1 in that following cycle and no overlap of accept and result.
REQ-023 SHALL ignore in_valid outside IDLE, with no input buffering.
REQ-024 SHALL, on dividend 0, produce q=0, rem=0, ovf=0 with the normal latency.

Reset
REQ-025 SHALL, while rst_n=0, force state IDLE, in_ready=1, out_valid=0, q=0, rem=0, ovf=0 and counter=0, asynchronously.
REQ-026 SHALL, on reset asserted mid-DIV or mid-DONE, discard the result with no out_valid pulse, and accept new input on the first edge after release.

Configuration
REQ-027 SHALL, when macro COEF_DIV_ROUND_EN is defined, round q to nearest: when 2*rem >= COEF, increment q, saturating at 2^QW-1 and setting ovf when the increment overflows. The increment SHALL add one DONE-entry cycle, making out_valid start at T+DW+2.
REQ-028 SHALL, when COEF_DIV_ROUND_EN is undefined, truncate q, keeping out_valid at T+DW+1 and using no rounding logic.

Verification
REQ-029 SHALL cover: in_data=2040, COEF=8 -> q=255, rem=0, ovf=0, out_valid at T+17.
REQ-030 SHALL cover: in_data=1037 -> q=129, rem=5; with COEF_DIV_ROUND_EN, q=130, rem=5, out_valid at T+18.
REQ-031 SHALL cover: in_data=65535 -> q=255, ovf=1, rem=7.
REQ-032 SHALL cover: out_ready held 0 for 5 cycles after out_valid -> outputs stable, in_ready=0, second in_valid ignored; one cycle after acceptance in_ready=1.
REQ-033 SHALL cover: rst_n pulsed low at step 8 of a division -> no out_valid, outputs 0, and the next input 8 -> q=1, rem=0.
REQ-034 SHALL cover: back-to-back inputs 0 and 2047 with out_ready=1 -> results (0,0,0) then (255,7,0) on consecutive transactions.
